// File: rtl/if_fetch_buf_pkg.sv
// Shared fetch-path constants: jump cause encoding, bus widths, default buffer depth, nop encoding.
package if_fetch_buf_pkg;

   localparam int IFB_DEPTH    = 4;
   localparam int INST_ADDR_W  = 32;
   localparam int INST_W       = 32;
   localparam int JUMP_CAUSE_W = 3;

   localparam logic [JUMP_CAUSE_W-1:0] JUMP_CAUSE_NO = '0;
   // addi x0, x0, 0
   localparam logic [INST_W-1:0]       INST_NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_ring.sv
// Fetch tag/data ring: push allocates a tag, fill completes the oldest unfilled slot, pop retires the head.
// Latency: head fields are combinational from registers; a fill is visible at the head the next cycle.
// Backpressure: none internally; the caller guarantees push only with a free slot and fill only with one outstanding.
module fetch_ring #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              push_predict,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_inst,
   input  logic              fill_fault,
   input  logic              pop,
   input  logic              clear,
   output logic [PTR_W:0]    alloc_ptr,
   output logic [PTR_W:0]    fill_ptr,
   output logic [PTR_W:0]    rd_ptr,
   output logic              head_vld,
   output logic [ADDR_W-1:0] head_pc,
   output logic              head_predict,
   output logic [DATA_W-1:0] head_inst,
   output logic              head_fault
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              predict;
      logic [DATA_W-1:0] inst;
      logic              fault;
   } entry_t;

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   entry_t           ring [DEPTH];
   logic [DEPTH-1:0] filled;
   logic [PTR_W-1:0] alloc_idx;
   logic [PTR_W-1:0] fill_idx;
   logic [PTR_W-1:0] rd_idx;

   assign alloc_idx = alloc_ptr[PTR_W-1:0];
   assign fill_idx  = fill_ptr[PTR_W-1:0];
   assign rd_idx    = rd_ptr[PTR_W-1:0];

   // Clear collapses the ring onto alloc_ptr so later pointer arithmetic stays continuous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
         filled    <= '0;
      end else if (clear) begin
         fill_ptr  <= alloc_ptr;
         rd_ptr    <= alloc_ptr;
         filled    <= '0;
      end else begin
         if (push) begin
            alloc_ptr         <= alloc_ptr + PTR_ONE;
            filled[alloc_idx] <= 1'b0;
         end
         if (fill) begin
            fill_ptr         <= fill_ptr + PTR_ONE;
            filled[fill_idx] <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         ring[alloc_idx].pc      <= push_pc;
         ring[alloc_idx].predict <= push_predict;
      end
      if (fill && !clear) begin
         ring[fill_idx].inst  <= fill_inst;
         ring[fill_idx].fault <= fill_fault;
      end
   end

   assign head_vld     = filled[rd_idx] & (rd_ptr != alloc_ptr);
   assign head_pc      = ring[rd_idx].pc;
   assign head_predict = ring[rd_idx].predict;
   assign head_inst    = ring[rd_idx].inst;
   assign head_fault   = ring[rd_idx].fault;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction fetch buffer between pc stage and decode; tags fetches with {pc, predict} and drops stale responses after a redirect.
// Latency: gnt in cycle c, rvalid earliest c+1, id_valid_o earliest c+2.
// Backpressure: no credit -> ibus_req_o low and hold_o high; decode stalls the head via id_ready_i.
module if_fetch_buf
   import if_fetch_buf_pkg::*;
#(
   parameter int DEPTH  = IFB_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int ADDR_W = INST_ADDR_W,
   parameter int DATA_W = INST_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_W-1:0]       pc_i,
   input  logic                    predict_i,
   input  logic [JUMP_CAUSE_W-1:0] jump_cause_i,
   output logic                    hold_o,
   output logic                    ibus_req_o,
   output logic [ADDR_W-1:0]       ibus_addr_o,
   input  logic                    ibus_gnt_i,
   input  logic                    ibus_rvalid_i,
   input  logic [DATA_W-1:0]       ibus_rdata_i,
   input  logic                    ibus_err_i,
   output logic                    id_valid_o,
   input  logic                    id_ready_i,
   output logic [DATA_W-1:0]       id_inst_o,
   output logic [ADDR_W-1:0]       id_pc_o,
   output logic                    id_predict_o,
   output logic                    id_fault_o
);

   localparam logic [PTR_W:0]    PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]    DEPTH_C = DEPTH[PTR_W:0];
   localparam logic [DATA_W-1:0] NOP     = DATA_W'(INST_NOP);

   logic              flush;
   logic              push;
   logic              fill;
   logic              pop;
   logic [PTR_W:0]    alloc_ptr;
   logic [PTR_W:0]    fill_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic [PTR_W:0]    alloc_cnt;
   logic [PTR_W:0]    in_flight;
   logic [PTR_W:0]    credit;
   logic [PTR_W:0]    drop_cnt;
   logic [PTR_W:0]    drop_nxt;
   logic              head_vld;
   logic [ADDR_W-1:0] head_pc;
   logic              head_predict;
   logic [DATA_W-1:0] head_inst;
   logic              head_fault;

   assign flush     = (jump_cause_i != JUMP_CAUSE_NO);
   assign alloc_cnt = alloc_ptr - rd_ptr;
   assign in_flight = alloc_ptr - fill_ptr;
   // Responses still owed to already-flushed fetches keep their slots reserved.
   assign credit    = DEPTH_C - alloc_cnt - drop_cnt;

   assign ibus_req_o  = ~rst & ~flush & (credit != '0);
   assign ibus_addr_o = pc_i;
   assign hold_o      = ~(ibus_req_o & ibus_gnt_i);

   assign push = ibus_req_o & ibus_gnt_i;
   assign fill = ibus_rvalid_i & ~flush & (drop_cnt == '0);
   assign pop  = id_valid_o & id_ready_i & ~flush;

   always_comb begin
      drop_nxt = drop_cnt;
      if (flush) begin
         // Every unreturned fetch becomes a drop; a response landing this cycle already paid for one.
         drop_nxt = drop_cnt + in_flight - (ibus_rvalid_i ? PTR_ONE : '0);
      end else if (ibus_rvalid_i && (drop_cnt != '0)) begin
         drop_nxt = drop_cnt - PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_nxt;
      end
   end

   fetch_ring #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ring (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .push_pc      (pc_i),
      .push_predict (predict_i),
      .fill         (fill),
      .fill_inst    (ibus_rdata_i),
      .fill_fault   (ibus_err_i),
      .pop          (pop),
      .clear        (flush),
      .alloc_ptr    (alloc_ptr),
      .fill_ptr     (fill_ptr),
      .rd_ptr       (rd_ptr),
      .head_vld     (head_vld),
      .head_pc      (head_pc),
      .head_predict (head_predict),
      .head_inst    (head_inst),
      .head_fault   (head_fault)
   );

   assign id_valid_o   = head_vld;
   assign id_inst_o    = head_vld ? head_inst : NOP;
   assign id_pc_o      = head_vld ? head_pc : '0;
   assign id_predict_o = head_vld & head_predict;
   assign id_fault_o   = head_vld & head_fault;

   rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
      ibus_rvalid_i |-> ((in_flight + drop_cnt) != '0));

   occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_if_fetch_buf.sv
// Randomized and directed bench for if_fetch_buf against a queue-based model of the fetch buffer.
module tb_if_fetch_buf;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        predict_i;
   logic [2:0]  jump_cause_i;
   logic        hold_o;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic        ibus_err_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;
   logic        id_predict_o;
   logic        id_fault_o;

   if_fetch_buf dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .predict_i     (predict_i),
      .jump_cause_i  (jump_cause_i),
      .hold_o        (hold_o),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .ibus_err_i    (ibus_err_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_inst_o     (id_inst_o),
      .id_pc_o       (id_pc_o),
      .id_predict_o  (id_predict_o),
      .id_fault_o    (id_fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic        filled;
      logic [31:0] inst;
      logic        fault;
   } ent_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   ent_t        mq[$];    // fetches the buffer owns, oldest first
   rsp_t        busq[$];  // responses the bus still owes, including stale ones
   int          mdrop = 0;
   int          total = 0;
   int          bad   = 0;
   bit          chk_en = 1'b0;
   logic [31:0] tgt = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_req();
      return (jump_cause_i == 3'd0) && ((DEPTH - mq.size() - mdrop) > 0);
   endfunction

   function automatic bit m_vld();
      return (mq.size() > 0) && mq[0].filled;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("req",   32'(ibus_req_o), 32'(m_req()));
         check("hold",  32'(hold_o), 32'(!(m_req() && ibus_gnt_i)));
         if (m_req()) check("addr", ibus_addr_o, pc_i);
         check("valid", 32'(id_valid_o), 32'(m_vld()));
         check("inst",  id_inst_o, m_vld() ? mq[0].inst : NOP);
         check("pc",    id_pc_o, m_vld() ? mq[0].pc : 32'h0);
         check("pred",  32'(id_predict_o), 32'(m_vld() ? mq[0].pred : 1'b0));
         check("fault", 32'(id_fault_o), 32'(m_vld() ? mq[0].fault : 1'b0));
      end
   end

   task automatic drive(input int p_gnt, input int p_rdy, input int p_rv, input int p_fl);
      ibus_gnt_i    = ($urandom_range(99) < p_gnt);
      id_ready_i    = ($urandom_range(99) < p_rdy);
      ibus_rvalid_i = (busq.size() > 0) && ($urandom_range(99) < p_rv);
      if (ibus_rvalid_i) begin
         ibus_rdata_i = busq[0].data;
         ibus_err_i   = busq[0].err;
      end else begin
         ibus_rdata_i = $urandom;
         ibus_err_i   = 1'($urandom_range(1));
      end
      if ($urandom_range(99) < p_fl) begin
         jump_cause_i = 3'($urandom_range(7, 1));
         tgt          = $urandom & 32'hFFFF_FFFC;
      end else begin
         jump_cause_i = 3'd0;
      end
   endtask

   // Advance one clock: update the model from the inputs seen at the edge, then move the pc stage.
   task automatic step();
      bit   fl, vld, acc, pop;
      int   nunf;
      rsp_t r;
      ent_t e;
      @(posedge clk);
      fl  = (jump_cause_i != 3'd0);
      vld = m_vld();
      acc = m_req() && ibus_gnt_i;
      pop = vld && id_ready_i && !fl;
      if (ibus_rvalid_i) busq.delete(0);
      if (fl) begin
         nunf = 0;
         foreach (mq[i]) if (!mq[i].filled) nunf++;
         mdrop = mdrop + nunf - (ibus_rvalid_i ? 1 : 0);
         mq.delete();
      end else begin
         if (ibus_rvalid_i) begin
            if (mdrop > 0) begin
               mdrop--;
            end else begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (!mq[i].filled) begin
                     mq[i].filled = 1'b1;
                     mq[i].inst   = ibus_rdata_i;
                     mq[i].fault  = ibus_err_i;
                     break;
                  end
               end
            end
         end
         if (pop) mq.delete(0);
         if (acc) begin
            e.pc = pc_i; e.pred = predict_i; e.filled = 1'b0; e.inst = 32'h0; e.fault = 1'b0;
            mq.push_back(e);
         end
      end
      if (acc) begin
         r.data = $urandom;
         r.err  = ($urandom_range(7) == 0);
         busq.push_back(r);
      end
      #1;
      if (fl) begin
         pc_i      = tgt;
         predict_i = 1'($urandom_range(1));
      end else if (acc) begin
         pc_i      = pc_i + 32'd4;
         predict_i = 1'($urandom_range(1));
      end
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      chk_en        = 1'b0;
      rst           = 1'b1;
      ibus_gnt_i    = 1'b0;
      ibus_rvalid_i = 1'b0;
      ibus_err_i    = 1'b0;
      ibus_rdata_i  = 32'h0;
      id_ready_i    = 1'b0;
      jump_cause_i  = 3'd0;
      predict_i     = 1'b0;
      pc_i          = start_pc;
      mq.delete();
      busq.delete();
      mdrop = 0;
      @(negedge clk);
      check("rst_req",   32'(ibus_req_o), 32'd0);
      check("rst_hold",  32'(hold_o), 32'd1);
      check("rst_valid", 32'(id_valid_o), 32'd0);
      check("rst_inst",  id_inst_o, NOP);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
   endtask

   // Runs full-throughput cycles until the first visible entry; checks its pc and how many cycles it took.
   task automatic first_valid(input string nm, input logic [31:0] exp_pc, input int exp_lat);
      int lat = -1;
      for (int j = 0; j < 20; j++) begin
         drive(100, 100, 100, 0);
         @(negedge clk);
         if (lat < 0 && id_valid_o) begin
            lat = j;
            check({nm, "_pc"}, id_pc_o, exp_pc);
         end
         step();
         if (lat >= 0) break;
      end
      check({nm, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      logic [7:0] t2_req;
      int ph_gnt[6] = '{70, 100, 40, 90, 100, 60};
      int ph_rdy[6] = '{60, 20, 100, 90, 0, 50};
      int ph_rv [6] = '{60, 90, 30, 90, 100, 50};
      int ph_fl [6] = '{3, 0, 5, 10, 2, 8};

      // streaming: one entry per cycle from cycle 2
      do_reset(32'h0);
      for (int i = 0; i < 6; i++) begin
         drive(100, 100, 100, 0);
         @(negedge clk);
         if (i >= 2 && i <= 4) begin
            check("t1_valid", 32'(id_valid_o), 32'd1);
            check("t1_pc", id_pc_o, 32'((i - 2) * 4));
         end
         step();
      end

      // credit exhaustion and a single pop releasing one request
      do_reset(32'h40);
      t2_req = 8'b0100_1111;
      for (int i = 0; i < 8; i++) begin
         drive(100, (i == 5) ? 100 : 0, 100, 0);
         @(negedge clk);
         check("t2_req",  32'(ibus_req_o), 32'(t2_req[i]));
         check("t2_hold", 32'(hold_o), 32'(!t2_req[i]));
         step();
      end

      // flush with 3 outstanding: three stale responses are swallowed
      do_reset(32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(100, 100, 0, 0);
         step();
      end
      drive(100, 100, 0, 100);
      tgt = 32'h100;
      step();
      first_valid("t3", 32'h100, 4);

      // flush colliding with a live response and a pop
      do_reset(32'h0);
      drive(100, 0, 0, 0);   step();
      drive(100, 0, 100, 0); step();
      drive(100, 0, 0, 0);   step();
      drive(0, 100, 100, 100);
      tgt = 32'h200;
      @(negedge clk);
      check("t4_pre_valid", 32'(id_valid_o), 32'd1);
      check("t4_rvalid", 32'(ibus_rvalid_i), 32'd1);
      step();
      drive(100, 100, 100, 0);
      @(negedge clk);
      check("t4_valid", 32'(id_valid_o), 32'd0);
      check("t4_req", 32'(ibus_req_o), 32'd1);
      step();
      first_valid("t4", 32'h200, 1);

      // faulted fetch
      do_reset(32'h10);
      drive(100, 100, 0, 0);
      step();
      busq[0].err = 1'b1;
      drive(0, 100, 100, 0);
      step();
      drive(0, 100, 0, 0);
      @(negedge clk);
      check("t5_valid", 32'(id_valid_o), 32'd1);
      check("t5_fault", 32'(id_fault_o), 32'd1);
      check("t5_pc", id_pc_o, 32'h10);
      step();

      // asynchronous reset with two filled entries
      do_reset(32'h80);
      drive(100, 0, 0, 0);   step();
      drive(100, 0, 100, 0); step();
      drive(0, 0, 100, 0);   step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t6_pre_valid", 32'(id_valid_o), 32'd1);
      #2;
      chk_en = 1'b0;
      rst    = 1'b1;
      #1;
      check("t6_valid", 32'(id_valid_o), 32'd0);
      check("t6_hold",  32'(hold_o), 32'd1);
      check("t6_req",   32'(ibus_req_o), 32'd0);
      check("t6_inst",  id_inst_o, NOP);

      // randomized phases
      do_reset(32'h1000);
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 500; c++) begin
            drive(ph_gnt[ph], ph_rdy[ph], ph_rv[ph], ph_fl[ph]);
            step();
         end
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
